// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Purpose:
//   Sequencer for an N-bit up/down count datapath. A run steps the count over
//   a window [lo, hi] in up, down or ping-pong mode. Turnarounds, natural run
//   completion and rejected starts are reported as single-cycle pulses.
//
// Optional feature:
//   SWEEP_CTRL_SWEEP_LIMIT_EN - when defined, a completed-sweep counter ends
//   the run after n_sweeps sweeps (n_sweeps == 0 runs until stop). When
//   undefined, n_sweeps is ignored, done is tied low and a run ends only via
//   stop or rst. The port list is the same in both builds.
//
// Ports:
//   clk        in   1         clock, all state changes on the rising edge
//   rst        in   1         synchronous active-high reset
//   start      in   1         request a run (honoured only when idle)
//   stop       in   1         abort the run; wins over start and hold
//   hold       in   1         freeze the run while high
//   mode       in   2         00 up, 01 down, 10 ping-pong, 11 treated as up
//   lo         in   WIDTH     window low bound, captured on accepted start
//   hi         in   WIDTH     window high bound, captured on accepted start
//   n_sweeps   in   NSWEEP_W  sweep budget, 0 = unlimited
//   count_out  out  WIDTH     current count
//   direction  out  1         0 = counting up, 1 = counting down
//   busy       out  1         high while a run is active
//   turn       out  1         pulse on every sweep-end / turnaround step
//   done       out  1         pulse on natural run completion
//   cfg_err    out  1         pulse when a start is rejected because lo > hi
// -----------------------------------------------------------------------------
module counter_sweep_ctrl #(
    parameter int WIDTH    = 3,
    parameter int NSWEEP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                hold,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [NSWEEP_W-1:0] n_sweeps,
    output logic [WIDTH-1:0]    count_out,
    output logic                direction,
    output logic                busy,
    output logic                turn,
    output logic                done,
    output logic                cfg_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0]       MODE_UP   = 2'b00;
    localparam logic [1:0]       MODE_DOWN = 2'b01;
    localparam logic [1:0]       MODE_PP   = 2'b10;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    state_e           state_q, state_d;
    logic [1:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q,   dir_d;
    logic             turn_q,  turn_d;
    logic             err_q,   err_d;

    // Candidate result of one run step, before hold/stop/terminal decisions.
    logic [WIDTH-1:0] step_count_s;
    logic             step_dir_s;
    logic             step_turn_s;
    logic             sweep_end_s;

`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
    logic                done_q,      done_d;
    logic [NSWEEP_W-1:0] nsw_q,       nsw_d;
    logic [NSWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [NSWEEP_W-1:0] sweep_cnt_inc_s;
    logic                terminal_s;
`else
    logic                unused_sweep_s;
`endif

    // Step proposal: where the count goes next and whether this step ends a sweep.
    always_comb begin
        step_count_s = count_q;
        step_dir_s   = dir_q;
        step_turn_s  = 1'b0;
        sweep_end_s  = 1'b0;
        case (mode_q)
            MODE_DOWN: begin
                if (count_q > lo_q) begin
                    step_count_s = count_q - CNT_ONE;
                end else begin
                    step_count_s = hi_q;
                    step_turn_s  = 1'b1;
                    sweep_end_s  = 1'b1;
                end
            end
            MODE_PP: begin
                if (!dir_q) begin
                    if (count_q < hi_q) begin
                        step_count_s = count_q + CNT_ONE;
                    end else begin
                        // Turn at the top; a degenerate window is a full sweep per step.
                        step_dir_s   = 1'b1;
                        step_turn_s  = 1'b1;
                        sweep_end_s  = (lo_q == hi_q);
                        step_count_s = (lo_q == hi_q) ? hi_q : (hi_q - CNT_ONE);
                    end
                end else begin
                    if (count_q > lo_q) begin
                        step_count_s = count_q - CNT_ONE;
                    end else begin
                        // Back at the bottom: lo..hi..lo is one sweep.
                        step_dir_s   = 1'b0;
                        step_turn_s  = 1'b1;
                        sweep_end_s  = 1'b1;
                        step_count_s = (lo_q == hi_q) ? lo_q : (lo_q + CNT_ONE);
                    end
                end
            end
            default: begin
                if (count_q < hi_q) begin
                    step_count_s = count_q + CNT_ONE;
                end else begin
                    step_count_s = lo_q;
                    step_turn_s  = 1'b1;
                    sweep_end_s  = 1'b1;
                end
            end
        endcase
    end

`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
    // The run is over when this sweep end brings the completed count up to the budget.
    assign sweep_cnt_inc_s = sweep_cnt_q + NSWEEP_W'(1);
    assign terminal_s      = sweep_end_s && (nsw_q != '0) && (sweep_cnt_inc_s == nsw_q);
`else
    assign unused_sweep_s  = ^{n_sweeps, sweep_end_s};
`endif

    // Next-state and registered-output logic for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        count_d = count_q;
        dir_d   = dir_q;
        turn_d  = 1'b0;
        err_d   = 1'b0;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
        done_d      = 1'b0;
        nsw_d       = nsw_q;
        sweep_cnt_d = sweep_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (lo > hi) begin
                        // Rejected start leaves count/direction untouched.
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mode_d  = (mode == 2'b11) ? MODE_UP : mode;
                        lo_d    = lo;
                        hi_d    = hi;
                        count_d = (mode == MODE_DOWN) ? hi : lo;
                        dir_d   = (mode == MODE_DOWN);
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
                        nsw_d       = n_sweeps;
                        sweep_cnt_d = '0;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Abort: count and direction keep their last values.
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_RUN;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
                end else if (terminal_s) begin
                    // Final sweep end: park on the endpoint instead of wrapping.
                    state_d = ST_IDLE;
                    turn_d  = 1'b1;
                    done_d  = 1'b1;
`endif
                end else begin
                    count_d = step_count_s;
                    dir_d   = step_dir_s;
                    turn_d  = step_turn_s;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
                    if (sweep_end_s) begin
                        sweep_cnt_d = sweep_cnt_inc_s;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UP;
            lo_q    <= '0;
            hi_q    <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            turn_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
            done_q      <= 1'b0;
            nsw_q       <= '0;
            sweep_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            err_q   <= err_d;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
            done_q      <= done_d;
            nsw_q       <= nsw_d;
            sweep_cnt_q <= sweep_cnt_d;
`endif
        end
    end

    assign count_out = count_q;
    assign direction = dir_q;
    assign busy      = (state_q == ST_RUN);
    assign turn      = turn_q;
    assign cfg_err   = err_q;
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
    assign done      = done_q;
`else
    assign done      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sweep_ctrl
//
// Self-checking bench for counter_sweep_ctrl (WIDTH=3, NSWEEP_W=4). A bench
// model predicts every output cycle by cycle into a scoreboard queue; a table
// of short runs and a few hand-written sequences add literal expectations.
// Expectations that depend on SWEEP_CTRL_SWEEP_LIMIT_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, hold;
    logic [1:0] mode;
    logic [2:0] lo, hi;
    logic [3:0] n_sweeps;
    logic [2:0] count_out;
    logic       direction, busy, turn, done, cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] cnt;
        logic       dir;
        logic       bsy;
        logic       trn;
        logic       dne;
        logic       err;
    } obs_t;

    obs_t sb_q[$];

    typedef struct {
        logic [1:0] mode;
        int         lo;
        int         hi;
        int         n;
        int         steps;
        int         first;
        int         cnt;
        int         dir;
        int         turns;
    } vec_t;

    vec_t vecs[6];

    int up_seq[7]  = '{3, 4, 5, 2, 3, 4, 5};
    int up_turn[7] = '{0, 0, 0, 1, 0, 0, 0};

    // Bench model state
    logic [2:0] m_cnt, m_lo, m_hi;
    logic       m_dir, m_busy, m_turn, m_done, m_err;
    logic [1:0] m_mode;
    logic [3:0] m_n, m_sw;

    counter_sweep_ctrl #(.WIDTH(3), .NSWEEP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .lo        (lo),
        .hi        (hi),
        .n_sweeps  (n_sweeps),
        .count_out (count_out),
        .direction (direction),
        .busy      (busy),
        .turn      (turn),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_edge();
        logic [2:0] nc;
        logic       nd;
        logic       end_sweep;
        m_turn = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_cnt  = 3'd0;
            m_dir  = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start && !stop) begin
                if (lo > hi) begin
                    m_err = 1'b1;
                end else begin
                    m_mode = (mode == 2'd3) ? 2'd0 : mode;
                    m_lo   = lo;
                    m_hi   = hi;
                    m_n    = n_sweeps;
                    m_sw   = 4'd0;
                    m_busy = 1'b1;
                    m_dir  = (m_mode == 2'd1);
                    m_cnt  = m_dir ? hi : lo;
                end
            end
        end else if (stop) begin
            m_busy = 1'b0;
        end else if (!hold) begin
            end_sweep = 1'b0;
            nc = m_cnt;
            nd = m_dir;
            if (m_mode == 2'd1) begin
                if (m_cnt > m_lo) nc = m_cnt - 3'd1;
                else begin nc = m_hi; m_turn = 1'b1; end_sweep = 1'b1; end
            end else if (m_mode == 2'd2) begin
                if (!m_dir && m_cnt < m_hi) nc = m_cnt + 3'd1;
                else if (m_dir && m_cnt > m_lo) nc = m_cnt - 3'd1;
                else begin
                    m_turn    = 1'b1;
                    nd        = !m_dir;
                    end_sweep = m_dir || (m_lo == m_hi);
                    if (m_lo == m_hi) nc = m_cnt;
                    else nc = m_dir ? m_lo + 3'd1 : m_hi - 3'd1;
                end
            end else begin
                if (m_cnt < m_hi) nc = m_cnt + 3'd1;
                else begin nc = m_lo; m_turn = 1'b1; end_sweep = 1'b1; end
            end
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
            if (end_sweep) begin
                m_sw = m_sw + 4'd1;
                if (m_n != 4'd0 && m_sw == m_n) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    nc     = m_cnt;
                    nd     = m_dir;
                end
            end
`endif
            m_cnt = nc;
            m_dir = nd;
        end
        sb_q.push_back({m_cnt, m_dir, m_busy, m_turn, m_done, m_err});
    endtask

    // One clock: predict, let the edge happen, then compare against the oldest prediction.
    task automatic tick();
        obs_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("scoreboard", 32'({count_out, direction, busy, turn, done, cfg_err}), 32'(e));
    endtask

    task automatic start_run(input logic [1:0] m, input logic [2:0] l, input logic [2:0] h,
                             input logic [3:0] n);
        mode = m; lo = l; hi = h; n_sweeps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int turns;
        int done_seen;

        vecs[0] = '{mode: 2'd0, lo: 2, hi: 5, n: 3, steps: 6,  first: 2, cnt: 4, dir: 0, turns: 1};
        vecs[1] = '{mode: 2'd1, lo: 1, hi: 4, n: 3, steps: 5,  first: 4, cnt: 3, dir: 1, turns: 1};
        vecs[2] = '{mode: 2'd2, lo: 0, hi: 7, n: 0, steps: 10, first: 0, cnt: 4, dir: 1, turns: 1};
        vecs[3] = '{mode: 2'd3, lo: 3, hi: 4, n: 5, steps: 5,  first: 3, cnt: 4, dir: 0, turns: 2};
        vecs[4] = '{mode: 2'd2, lo: 2, hi: 3, n: 4, steps: 5,  first: 2, cnt: 3, dir: 0, turns: 4};
        vecs[5] = '{mode: 2'd0, lo: 5, hi: 5, n: 0, steps: 4,  first: 5, cnt: 5, dir: 0, turns: 4};

        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 2'd0; lo = 3'd0; hi = 3'd0; n_sweeps = 4'd0;
        m_cnt = 3'd0; m_lo = 3'd0; m_hi = 3'd0; m_dir = 1'b0; m_busy = 1'b0;
        m_turn = 1'b0; m_done = 1'b0; m_err = 1'b0; m_mode = 2'd0; m_n = 4'd0; m_sw = 4'd0;

        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_dir", 32'(direction), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({turn, done, cfg_err}), 32'd0);
        rst = 1'b0;

        // Table-driven short runs, all stopped before any sweep budget is reached
        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i].mode, 3'(vecs[i].lo), 3'(vecs[i].hi), 4'(vecs[i].n));
            check("vec_first", 32'(count_out), 32'(vecs[i].first));
            check("vec_busy", 32'(busy), 32'd1);
            turns = 0;
            for (int s = 0; s < vecs[i].steps; s++) begin
                tick();
                if (turn) turns++;
            end
            check("vec_cnt", 32'(count_out), 32'(vecs[i].cnt));
            check("vec_dir", 32'(direction), 32'(vecs[i].dir));
            check("vec_turns", 32'(turns), 32'(vecs[i].turns));
            stop_run();
            check("vec_stop_busy", 32'(busy), 32'd0);
            check("vec_stop_hold", 32'({count_out, done}), 32'({3'(vecs[i].cnt), 1'b0}));
        end

        // Up 2..5, two sweeps
        start_run(2'd0, 3'd2, 3'd5, 4'd2);
        check("up_first", 32'(count_out), 32'd2);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("up_cnt", 32'(count_out), 32'(up_seq[i]));
            check("up_turn", 32'(turn), 32'(up_turn[i]));
        end
        tick();
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
        check("up_final", 32'({count_out, turn, done, busy}), 32'({3'd5, 1'b1, 1'b1, 1'b0}));
        tick();
        check("up_after_done", 32'({count_out, busy, turn, done}), 32'({3'd5, 3'b000}));
`else
        check("up_wrap", 32'({count_out, turn, done, busy}), 32'({3'd2, 1'b1, 1'b0, 1'b1}));
        stop_run();
`endif

        // Ping-pong 0..7, one sweep
        start_run(2'd2, 3'd0, 3'd7, 4'd1);
        turns = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("pp_cnt", 32'(count_out), 32'((i <= 7) ? i : 14 - i));
            check("pp_dir", 32'(direction), 32'(i >= 8));
            if (turn) turns++;
        end
        check("pp_turns", 32'(turns), 32'd1);
        tick();
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
        check("pp_final", 32'({count_out, turn, done, busy}), 32'({3'd0, 1'b1, 1'b1, 1'b0}));
`else
        check("pp_wrap", 32'({count_out, direction, turn, busy}), 32'({3'd1, 1'b0, 1'b1, 1'b1}));
        stop_run();
`endif

        // Hold for three cycles at 3, resume, then stop
        start_run(2'd0, 3'd0, 3'd7, 4'd0);
        tick(); tick(); tick();
        check("hold_pre", 32'(count_out), 32'd3);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_frozen", 32'({count_out, busy, turn}), 32'({3'd3, 1'b1, 1'b0}));
        end
        hold = 1'b0;
        tick();
        check("hold_resume", 32'(count_out), 32'd4);
        stop_run();
        check("hold_stop", 32'({count_out, busy, done}), 32'({3'd4, 1'b0, 1'b0}));

        // Rejected start, then a valid one
        mode = 2'd0; lo = 3'd6; hi = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err_pulse", 32'({cfg_err, busy, count_out}), 32'({1'b1, 1'b0, 3'd4}));
        tick();
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        start_run(2'd0, 3'd3, 3'd6, 4'd0);
        check("cfg_ok", 32'({busy, count_out}), 32'({1'b1, 3'd3}));
        stop_run();

        // Reset in the middle of a down run, then start+stop together
        start_run(2'd1, 3'd0, 3'd7, 4'd0);
        check("down_first", 32'({count_out, direction}), 32'({3'd7, 1'b1}));
        tick(); tick(); tick();
        check("down_at4", 32'(count_out), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst", 32'({count_out, direction, busy, turn, done, cfg_err}), 32'd0);
        lo = 3'd0; hi = 3'd7; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'({busy, cfg_err}), 32'd0);
        tick();
        check("start_stop_idle2", 32'(busy), 32'd0);

        // Long wrap run with no natural end
`ifdef SWEEP_CTRL_SWEEP_LIMIT_EN
        start_run(2'd0, 3'd0, 3'd7, 4'd0);
`else
        start_run(2'd0, 3'd0, 3'd7, 4'd1);
`endif
        done_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("wrap_cnt", 32'(count_out), 32'(i % 8));
            if (done) done_seen++;
        end
        check("wrap_no_done", 32'(done_seen), 32'd0);
        stop_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
